// File: rtl/counter_sweep_ctrl.sv
// Command generator for the up/down counter: after an accepted start it sweeps
// a count 0 -> limit -> 0 for the requested number of sweeps, then pulses done.
module counter_sweep_ctrl #(
  parameter int N   = 8,
  parameter int S_W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           hold,
  input  logic [N-1:0]   limit,
  input  logic [S_W-1:0] sweeps,
  output logic [N-1:0]   count,
  output logic           dir,
  output logic           busy,
  output logic           at_peak,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  localparam logic [N-1:0]   CNT_ONE  = N'(1);
  localparam logic [S_W-1:0] LEFT_ONE = S_W'(1);

  state_t         state_q, state_d;
  logic [N-1:0]   count_q, count_d;
  logic [N-1:0]   limit_q, limit_d;
  logic [S_W-1:0] left_q,  left_d;
  logic           dir_q,   dir_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic           err_q,   err_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    left_d  = left_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
      dir_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (limit != '0 && sweeps != '0) begin
              limit_d = limit;
              left_d  = sweeps;
              state_d = UP;
              count_d = '0;
              dir_d   = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        UP: begin
          if (!hold) begin
            // Turning at limit_q (not at overflow) keeps limit = 2^N-1 legal.
            if (count_q != limit_q) begin
              count_d = count_q + CNT_ONE;
            end else begin
              state_d = DOWN;
              dir_d   = 1'b1;
              count_d = limit_q - CNT_ONE;
            end
          end
        end
        DOWN: begin
          if (!hold) begin
            if (count_q != '0) begin
              count_d = count_q - CNT_ONE;
            end else if (left_q > LEFT_ONE) begin
              left_d  = left_q - LEFT_ONE;
              state_d = UP;
              dir_d   = 1'b0;
              count_d = CNT_ONE;
            end else begin
              // done_q is high exactly for the cycle spent in DONE.
              state_d = DONE;
              done_d  = 1'b1;
              dir_d   = 1'b0;
              count_d = '0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          count_d = '0;
          dir_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == UP) || (state_d == DOWN);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      left_q  <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      left_q  <= left_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign at_peak = busy_q && (count_q == limit_q);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl: expected per-cycle outputs are queued
// when a command is issued and compared on each falling edge.
module tb_counter_sweep_ctrl;

  typedef struct packed {
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       at_peak;
    logic       done;
    logic       err;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       hold  = 1'b0;
  logic [7:0] limit = '0;
  logic [7:0] sweeps = '0;
  logic [7:0] count;
  logic       dir, busy, at_peak, done, err;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_sweep_ctrl #(.N(8), .S_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .limit(limit), .sweeps(sweeps), .count(count), .dir(dir), .busy(busy),
    .at_peak(at_peak), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    return '{count: count, dir: dir, busy: busy, at_peak: at_peak, done: done, err: err};
  endfunction

  function automatic obs_t rec(int c, bit d, bit b, bit p, bit dn, bit e);
    return '{count: 8'(c), dir: d, busy: b, at_peak: p, done: dn, err: e};
  endfunction

  // Reference sequence: first sweep climbs from 0, later ones from 1; each
  // sweep descends to 0; then one DONE cycle and one idle cycle.
  task automatic push_sweep(input int l, input int s);
    for (int k = 0; k < s; k++) begin
      for (int v = (k == 0) ? 0 : 1; v <= l; v++) exp_q.push_back(rec(v, 0, 1, v == l, 0, 0));
      for (int v = l - 1; v >= 0; v--) exp_q.push_back(rec(v, 1, 1, 0, 0, 0));
    end
    exp_q.push_back(rec(0, 0, 0, 0, 1, 0));
    exp_q.push_back(rec(0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    obs_t o, e;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    o = sample();
    e = rec(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_init: got %h want %h", o, e); end
    reset = 1'b0;
    // Reset in the middle of a sweep.
    limit = 8'd5; sweeps = 8'd2; start = 1'b1;
    push_sweep(5, 2);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      start = 1'b0;
      o = sample();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_pre cyc%0d: got %h want %h", i, o, e); end
    end
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    o = sample();
    e = rec(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_mid: got %h want %h", o, e); end
  endtask

  task automatic run_sweep(input string name, input int l, input int s,
                           input bool_poke, input int peaks_exp);
    obs_t o, e;
    int n_busy = 0, n_done = 0, n_peak = 0, cyc = 0;
    limit = 8'(l); sweeps = 8'(s); start = 1'b1;
    push_sweep(l, s);
    while (exp_q.size() > 0) begin
      @(negedge clock);
      start = 1'b0;
      // Optionally poke start and limit mid-sweep: both must be ignored.
      if (bool_poke && cyc == 3) begin start = 1'b1; limit = 8'd7; end
      o = sample();
      e = exp_q.pop_front();
      n_busy += o.busy; n_done += o.done; n_peak += o.at_peak;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL %s cyc%0d: got %h want %h", name, cyc, o, e); end
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (n_busy != 2 * l * s + 1) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, n_busy, 2 * l * s + 1); end
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL %s done_pulses: got %0d want 1", name, n_done); end
    n_cmp++;
    if (n_peak != peaks_exp) begin n_bad++; $display("FAIL %s peak_cycles: got %0d want %0d", name, n_peak, peaks_exp); end
  endtask

  task automatic test_single();
    run_sweep("single_l3", 3, 1, 1'b0, 1);
  endtask

  task automatic test_multi();
    run_sweep("multi_l2s3", 2, 3, 1'b1, 3);
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_l1s2", 1, 2, 1'b0, 2);
    run_sweep("b2b_l4s1", 4, 1, 1'b0, 1);
  endtask

  task automatic test_max_limit();
    run_sweep("max_l255", 255, 1, 1'b0, 1);
  endtask

  task automatic test_err();
    obs_t o, e;
    for (int t = 0; t < 2; t++) begin
      limit  = (t == 0) ? 8'd0 : 8'd4;
      sweeps = (t == 0) ? 8'd5 : 8'd0;
      start  = 1'b1;
      exp_q.push_back(rec(0, 0, 0, 0, 0, 1));
      exp_q.push_back(rec(0, 0, 0, 0, 0, 0));
      exp_q.push_back(rec(0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        start = 1'b0;
        o = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL err_case%0d cyc%0d: got %h want %h", t, i, o, e); end
      end
    end
  endtask

  task automatic test_hold_stop();
    obs_t o, e;
    int n_done = 0;
    limit = 8'd5; sweeps = 8'd1; start = 1'b1;
    for (int v = 0; v <= 4; v++) exp_q.push_back(rec(v, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(rec(4, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(rec(0, 0, 0, 0, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      start = 1'b0;
      o = sample();
      e = exp_q.pop_front();
      n_done += o.done;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL hold_stop cyc%0d: got %h want %h", i, o, e); end
      // Hold for four edges once count shows 4, then stop on the next.
      hold = (i >= 4 && i < 8);
      stop = (i == 8);
    end
    hold = 1'b0; stop = 1'b0;
    n_cmp++;
    if (n_done != 0) begin n_bad++; $display("FAIL hold_stop done_pulses: got %0d want 0", n_done); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_multi();
    test_err();
    test_hold_stop();
    test_back_to_back();
    test_max_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
